// File: rtl/fe_redirect_ctrl_pkg.sv
// Shared types and defaults for the front-end redirect controller.
// Redirect source encoding doubles as the priority class (higher value wins).
package fe_redirect_ctrl_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;

  typedef enum logic [1:0] {
    SRC_NONE       = 2'd0,
    SRC_BRANCH     = 2'd1,
    SRC_MISPREDICT = 2'd2,
    SRC_EXCEPTION  = 2'd3
  } redirect_src_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_RECOVER = 2'd2
  } fe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fe_redirect_ctrl.sv
// Front-end redirect controller: prioritises exception / mispredict / branch
// redirects, holds backend redirects across stalls and masks stale branches.
module fe_redirect_ctrl
  import fe_redirect_ctrl_pkg::*;
#(
  parameter int WORD_SIZE_P      = DEFAULT_WORD_SIZE,
  parameter int EPOCH_WIDTH_P    = 2,
  parameter int RECOVER_CYCLES_P = 2,
  parameter int CNT_WIDTH_P      = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     ready_i,
  input  logic                     exc_v_i,
  input  logic [WORD_SIZE_P-1:0]   exc_vector_i,
  input  logic                     mis_predict_i,
  input  logic [WORD_SIZE_P-1:0]   mis_target_i,
  input  logic                     br_take_i,
  input  logic [WORD_SIZE_P-1:0]   br_target_i,
  output logic                     redirect_v_o,
  output logic [WORD_SIZE_P-1:0]   redirect_pc_o,
  output logic [1:0]               redirect_src_o,
  output logic                     flush_f_d_o,
  output logic                     flush_d_b_o,
  output logic [EPOCH_WIDTH_P-1:0] epoch_o,
  output logic                     busy_o,
  output logic [CNT_WIDTH_P-1:0]   exc_cnt_o,
  output logic [CNT_WIDTH_P-1:0]   mis_cnt_o,
  output logic [CNT_WIDTH_P-1:0]   br_cnt_o,
  output logic [1:0]               state_o
);

  localparam int RC_W = (RECOVER_CYCLES_P > 1) ? $clog2(RECOVER_CYCLES_P) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES_P - 1);

  // Handshake: redirect_v_o is a one-cycle command with no back-pressure; the
  // front end must take redirect_pc_o in any cycle where redirect_v_o=1, and
  // issue only happens when ready_i=1.

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  fe_state_e             state_q, state_d;
  logic [RC_W-1:0]       rc_q, rc_d;
  logic [WORD_SIZE_P-1:0] pend_pc_q, pend_pc_d;
  redirect_src_e         pend_src_q, pend_src_d;
  logic [EPOCH_WIDTH_P-1:0] epoch_q;

  logic                   be_v;
  logic [WORD_SIZE_P-1:0] be_pc;
  redirect_src_e          be_src;
  logic                   br_ok;
  logic                   issue_v;
  logic [WORD_SIZE_P-1:0] sel_pc;
  redirect_src_e          sel_src;

  // Backend candidate; a held exception is never displaced by a mispredict.
  always_comb begin
    be_v   = 1'b0;
    be_pc  = '0;
    be_src = SRC_NONE;
    if (exc_v_i) begin
      be_v   = 1'b1;
      be_pc  = exc_vector_i;
      be_src = SRC_EXCEPTION;
    end else if (mis_predict_i &&
                 !((state_q == ST_PEND) && (pend_src_q == SRC_EXCEPTION))) begin
      be_v   = 1'b1;
      be_pc  = mis_target_i;
      be_src = SRC_MISPREDICT;
    end else if (state_q == ST_PEND) begin
      be_v   = 1'b1;
      be_pc  = pend_pc_q;
      be_src = pend_src_q;
    end
  end

  always_comb begin
    br_ok   = br_take_i && (state_q == ST_IDLE);
    sel_pc  = '0;
    sel_src = SRC_NONE;
    if (be_v) begin
      sel_pc  = be_pc;
      sel_src = be_src;
    end else if (br_ok) begin
      sel_pc  = br_target_i;
      sel_src = SRC_BRANCH;
    end
    issue_v = rst_n && ready_i && (be_v || br_ok);
  end

  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    pend_pc_d  = pend_pc_q;
    pend_src_d = pend_src_q;
    case (state_q)
      ST_IDLE, ST_RECOVER: begin
        if (be_v && ready_i) begin
          state_d = ST_RECOVER;
          rc_d    = RC_LOAD;
        end else if (be_v) begin
          state_d    = ST_PEND;
          pend_pc_d  = be_pc;
          pend_src_d = be_src;
        end else if (state_q == ST_RECOVER) begin
          if (rc_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            rc_d = rc_q - RC_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (ready_i) begin
          state_d    = ST_RECOVER;
          rc_d       = RC_LOAD;
          pend_pc_d  = '0;
          pend_src_d = SRC_NONE;
        end else begin
          pend_pc_d  = be_pc;
          pend_src_d = be_src;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rc_q       <= '0;
      pend_pc_q  <= '0;
      pend_src_q <= SRC_NONE;
      epoch_q    <= '0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      pend_pc_q  <= pend_pc_d;
      pend_src_q <= pend_src_d;
      if (issue_v) begin
        epoch_q <= epoch_q + EPOCH_WIDTH_P'(1);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH_P)) u_exc_cnt (
    .clk   (clk_i),
    .rst_n (rst_n),
    .inc   (issue_v && (sel_src == SRC_EXCEPTION)),
    .count (exc_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH_P)) u_mis_cnt (
    .clk   (clk_i),
    .rst_n (rst_n),
    .inc   (issue_v && (sel_src == SRC_MISPREDICT)),
    .count (mis_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH_P)) u_br_cnt (
    .clk   (clk_i),
    .rst_n (rst_n),
    .inc   (issue_v && (sel_src == SRC_BRANCH)),
    .count (br_cnt_o)
  );

  assign redirect_v_o   = issue_v;
  assign redirect_pc_o  = issue_v ? sel_pc : '0;
  assign redirect_src_o = issue_v ? sel_src : SRC_NONE;
  assign flush_f_d_o    = issue_v;
  assign flush_d_b_o    = issue_v;
  assign epoch_o        = epoch_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_fe_redirect_ctrl.sv
// Bench for fe_redirect_ctrl: directed scenarios plus random traffic, all
// checked against a cycle-level reference model of the redirect rules.
module tb_fe_redirect_ctrl;

  localparam int W = 16;
  localparam int E = 2;
  localparam int R = 2;
  localparam int C = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n_i;
  always #5 clk = ~clk;

  logic         ready_i, exc_v_i, mis_predict_i, br_take_i;
  logic [W-1:0] exc_vector_i, mis_target_i, br_target_i;
  logic         redirect_v_o, flush_f_d_o, flush_d_b_o, busy_o;
  logic [W-1:0] redirect_pc_o;
  logic [1:0]   redirect_src_o, state_dbg;
  logic [E-1:0] epoch_o;
  logic [C-1:0] exc_cnt_o, mis_cnt_o, br_cnt_o;

  fe_redirect_ctrl #(
    .WORD_SIZE_P(W), .EPOCH_WIDTH_P(E), .RECOVER_CYCLES_P(R), .CNT_WIDTH_P(C)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .ready_i(ready_i),
    .exc_v_i(exc_v_i), .exc_vector_i(exc_vector_i),
    .mis_predict_i(mis_predict_i), .mis_target_i(mis_target_i),
    .br_take_i(br_take_i), .br_target_i(br_target_i),
    .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o),
    .redirect_src_o(redirect_src_o), .flush_f_d_o(flush_f_d_o),
    .flush_d_b_o(flush_d_b_o), .epoch_o(epoch_o), .busy_o(busy_o),
    .exc_cnt_o(exc_cnt_o), .mis_cnt_o(mis_cnt_o), .br_cnt_o(br_cnt_o),
    .state_o(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state: what is owed, how long branches stay masked
  bit           m_pend_v;
  logic [1:0]   m_pend_src;
  logic [W-1:0] m_pend_pc;
  int           m_recover;
  int           m_epoch;
  int           m_cnt[4];
  logic [W+1:0] exp_q[$];

  task automatic model_reset();
    m_pend_v = 0; m_pend_src = 0; m_pend_pc = '0;
    m_recover = 0; m_epoch = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  // drive one cycle, check outputs at negedge, then advance the model
  task automatic step(input bit rdy, input bit e, input logic [W-1:0] ev,
                      input bit m, input logic [W-1:0] mv,
                      input bit b, input logic [W-1:0] bt);
    logic [1:0]   cs;
    logic [W-1:0] cpc;
    bit           bk, exp_v;
    ready_i = rdy; exc_v_i = e; exc_vector_i = ev;
    mis_predict_i = m; mis_target_i = mv; br_take_i = b; br_target_i = bt;
    @(negedge clk);
    cs = 2'd0; cpc = '0; bk = 0;
    if (e) begin
      cs = 2'd3; cpc = ev; bk = 1;
    end else if (m && !(m_pend_v && m_pend_src == 2'd3)) begin
      cs = 2'd2; cpc = mv; bk = 1;
    end else if (m_pend_v) begin
      cs = m_pend_src; cpc = m_pend_pc; bk = 1;
    end else if (b && m_recover == 0) begin
      cs = 2'd1; cpc = bt;
    end
    exp_v = rdy && (cs != 2'd0);
    if (exp_v) exp_q.push_back({cs, cpc});

    if (exp_q.size() != 0)
      check("redirect", {13'd0, redirect_v_o, redirect_src_o, redirect_pc_o}, {13'd0, 1'b1, exp_q.pop_front()});
    else
      check("no_redirect", {29'd0, redirect_v_o, redirect_src_o}, 32'd0);
    check("flush_f_d", {31'd0, flush_f_d_o}, {31'd0, exp_v});
    check("flush_d_b", {31'd0, flush_d_b_o}, {31'd0, exp_v});
    check("epoch", {30'd0, epoch_o}, m_epoch);
    check("busy", {31'd0, busy_o}, {31'd0, (m_pend_v || m_recover > 0)});
    check("exc_cnt", {16'd0, exc_cnt_o}, m_cnt[3]);
    check("mis_cnt", {16'd0, mis_cnt_o}, m_cnt[2]);
    check("br_cnt", {16'd0, br_cnt_o}, m_cnt[1]);

    if (exp_v) begin
      m_epoch = (m_epoch + 1) % (1 << E);
      if (m_cnt[cs] < (1 << C) - 1) m_cnt[cs]++;
      if (bk) begin
        m_pend_v = 0; m_recover = R;
      end
    end else if (bk && !rdy) begin
      m_pend_v = 1; m_pend_src = cs; m_pend_pc = cpc; m_recover = 0;
    end else if (m_recover > 0) begin
      m_recover--;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(rdy, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n_i = 1'b1;
    idle(1, 3);
  endtask

  initial begin
    reset_n_i = 1'b0;
    ready_i = 0; exc_v_i = 0; mis_predict_i = 0; br_take_i = 0;
    exc_vector_i = '0; mis_target_i = '0; br_target_i = '0;
    model_reset();
    #1;
    check("reset_redirect_v", {31'd0, redirect_v_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_epoch", {30'd0, epoch_o}, 32'd0);
    @(posedge clk); #1;
    do_reset();

    // mispredict issues same cycle, then two recovery cycles
    step(1, 0, '0, 1, 16'h0040, 0, '0);
    idle(1, 3);

    // mispredict held across a 3-cycle stall
    step(0, 0, '0, 1, 16'h0100, 0, '0);
    idle(0, 2);
    idle(1, 4);

    // exception + mispredict + branch together: only exception issues
    step(1, 1, 16'h0008, 1, 16'h0200, 1, 16'h0300);
    idle(1, 4);

    // branch held high through recovery issues only once back in idle
    step(1, 0, '0, 1, 16'h0400, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, '0, 1, 16'h0500);
    idle(1, 2);

    // held exception survives a later mispredict during the stall
    step(0, 1, 16'h0010, 0, '0, 0, '0);
    step(0, 0, '0, 1, 16'h0600, 0, '0);
    idle(1, 4);

    // reset while pending drops the held redirect
    step(0, 0, '0, 1, 16'h0180, 0, '0);
    ready_i = 1; mis_predict_i = 1; mis_target_i = 16'h0190;
    reset_n_i = 1'b0;
    #1;
    check("rst_mid_redirect_v", {31'd0, redirect_v_o}, 32'd0);
    check("rst_mid_flush", {30'd0, flush_f_d_o, flush_d_b_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    mis_predict_i = 0;
    @(posedge clk); #1;
    do_reset();
    idle(1, 3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, W'($urandom),
           $urandom_range(0, 5) == 0, W'($urandom),
           $urandom_range(0, 2) == 0, W'($urandom));
    end
    idle(1, 4);

    // branch counter saturation
    do_reset();
    for (int i = 0; i < 65539; i++) step(1, 0, '0, 0, '0, 1, W'(i));
    check("br_cnt_saturated", {16'd0, br_cnt_o}, 32'h0000_FFFF);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fe_redirect_ctrl.md
# fe_redirect_ctrl

Front-end redirect controller sitting between the redirect sources and the `pc_next` / fetch-decode / decode-branch pipe flush inputs. It arbitrates three PC-redirect requesters by fixed priority: backend exception, backend mispredict, and the static branch-stage taken branch. It holds a backend redirect that arrives while the front end is stalled, and blocks stale branch-stage redirects during a recovery window. It maintains a redirect epoch and per-source event counters.

## Interface
- `WORD_SIZE_P`, 16, PC/target width
- `EPOCH_WIDTH_P`, 2, redirect epoch tag width
- `RECOVER_CYCLES_P`, 2, cycles branch-stage redirects are ignored after a backend redirect issues (≥1)
- `CNT_WIDTH_P`, 16, width of each saturating event counter

Ports:
- `clk_i` in 1: clock
- `reset_n_i` in 1: asynchronous active-low reset
- `ready_i` in 1: front end may advance; 0 = stall
- `exc_v_i` in 1: exception redirect request (single-cycle pulse)
- `exc_vector_i` in `WORD_SIZE_P`: exception target
- `mis_predict_i` in 1: backend mispredict request (single-cycle pulse)
- `mis_target_i` in `WORD_SIZE_P`: corrected target
- `br_take_i` in 1: branch-stage static taken (level, re-presented while stalled)
- `br_target_i` in `WORD_SIZE_P`: branch-stage target
- `redirect_v_o` out 1: load `redirect_pc_o` into the PC this cycle
- `redirect_pc_o` out `WORD_SIZE_P`: redirect target
- `redirect_src_o` out 2: 0 none, 1 branch, 2 mispredict, 3 exception
- `flush_f_d_o` / `flush_d_b_o` out 1: pipe flushes; each equals `redirect_v_o`
- `epoch_o` out `EPOCH_WIDTH_P`: current epoch, tags decoded instructions
- `busy_o` out 1: state ≠ IDLE
- `exc_cnt_o`, `mis_cnt_o`, `br_cnt_o` out `CNT_WIDTH_P`: issued redirects per source

## Operation
- States: IDLE, PEND (backend request latched, waiting for `ready_i`), RECOVER (counting down `RECOVER_CYCLES_P`).
- Candidate selection each cycle: new `exc_v_i` > new `mis_predict_i` > pending register > `br_take_i`.
  - In PEND, a new request of equal or higher class replaces the pending one.
  - A pending exception is not replaced by a new mispredict.
  - `br_take_i` is ignored in PEND and RECOVER.
- Issue occurs only when `ready_i`=1: `redirect_v_o`=1, target/src from the winner, flushes asserted.
- With `ready_i`=0, nothing issues.
  - A backend request is latched (target + class) and the state goes to PEND.
  - `br_take_i` is dropped; the branch stage re-presents it.
- IDLE transitions:
  - backend issue → RECOVER (counter loaded `RECOVER_CYCLES_P`-1)
  - backend while stalled → PEND
  - branch issue → stays IDLE
- PEND + `ready_i`: issue, clear pending, → RECOVER.
- RECOVER:
  - A new backend request behaves as in IDLE and reloads the counter.
  - Otherwise the counter decrements; at 0 → IDLE.
- Epoch: increments modulo 2^`EPOCH_WIDTH_P` on every issued redirect of any source.
- Counters: increment the source counter on issue; saturate at all-ones.

## Timing
- Request → `redirect_v_o` is combinational, same cycle, when `ready_i`=1 and not pending.
- Pending issues from registers in the first cycle `ready_i`=1.
- `epoch_o`, counters and state update on the clock edge ending the issue cycle.
- Reset (async assert, sync deassert internally):
  - state IDLE, pending cleared, epoch 0, counters 0.
  - `redirect_v_o`/flushes forced 0 while `reset_n_i`=0.
- Reset mid-PEND discards the pending redirect.
- Epoch wrap 3→0 is legal; consumers compare for equality only.
- Simultaneous `exc_v_i` and `mis_predict_i`: exception wins, mispredict is discarded (not queued).

## Structure
- Shared package adds `redirect_src_e` (NONE, BRANCH, MISPREDICT, EXCEPTION) and the `fe_state_e` enum.
- `WORD_SIZE_P` comes from the package default.
- One sub-module, `sat_counter`, instantiated three times.
- Arbitration and FSM live in the top.

## Test plan
- `ready_i`=1, `mis_predict_i` pulse target 0x0040 → same-cycle `redirect_v_o`=1, src=2, pc=0x0040, flushes=1; next cycle `epoch_o`=1, `busy_o`=1 for 2 cycles.
- `ready_i`=0, `mis_predict_i` pulse 0x0100, stall 3 cycles → no redirect during stall; first ready cycle issues 0x0100 src=2.
- Same cycle `exc_v_i` (0x0008) + `mis_predict_i` (0x0200) + `br_take_i` (0x0300) → issues 0x0008 src=3; mispredict is not issued later.
- RECOVER with `br_take_i`=1 (0x0500) → no redirect until back in IDLE; then 0x0500 issues, src=1.
- PEND holding exception, new mispredict while stalled → exception retained and issued.
- Assert `reset_n_i`=0 while PEND → outputs 0 immediately; after release there is no redirect, `epoch_o`=0, counters 0.
- 2^16+3 branch issues → `br_cnt_o`=0xFFFF.
